sr_cmd_driver: RTL and testbench

Command-side driver for the team's synchronous SR flip-flop. It accepts a requested output level over a valid/ready handshake and generates a registered set or reset pulse on `s` or `r`. It then watches the flip-flop's `q` until `q` matches the requested level, and reports `done` on success or `err` on timeout. The block never asserts `s` and `r` together, so the flip-flop's forbidden S=R=1 input can never occur.

---
 rtl/sr_pkg.sv | 18 +
 rtl/sr_cmd_if.sv | 28 ++
 rtl/sr_cmd_driver.sv | 125 ++++++++++++
 tb/tb_sr_cmd_driver.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop command driver and its benches.
//   sr_state_t  : driver FSM state encoding
//   SR_LVL_SET  : requested level that drives a set pulse on s
//   SR_LVL_CLR  : requested level that drives a reset pulse on r
package sr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT,
    DONE,
    ERR
  } sr_state_t;

  localparam logic SR_LVL_SET = 1'b1;
  localparam logic SR_LVL_CLR = 1'b0;

endpackage

// File: rtl/sr_cmd_if.sv
// Requester-side command bus for sr_cmd_driver.
//   req_valid / req_level / req_ready : command handshake (level 1 = set)
//   busy    : driver is not idle
//   done    : one-cycle completion pulse, qualified by skipped
//   skipped : q already matched at accept, no pulse issued
//   err     : one-cycle timeout pulse
// master = requester, slave = driver.
interface sr_cmd_if;

  logic req_valid;
  logic req_level;
  logic req_ready;
  logic busy;
  logic done;
  logic skipped;
  logic err;

  modport master (
    output req_valid, req_level,
    input  req_ready, busy, done, skipped, err
  );

  modport slave (
    input  req_valid, req_level,
    output req_ready, busy, done, skipped, err
  );

endinterface

// File: rtl/sr_cmd_driver.sv
// Command driver for a synchronous SR flip-flop. Accepts a target level,
// issues a registered set or reset pulse of PULSE_LEN cycles, then waits up
// to TIMEOUT cycles for q to follow and reports done (optionally skipped)
// or err. s and r are decoded from one latched level, so both can never be
// high together.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : sr_cmd_if.slave command handshake and status
//   q     : flip-flop output fed back (same clock domain)
//   s, r  : registered set / reset pulses to the flip-flop
module sr_cmd_driver
  import sr_pkg::*;
#(
  parameter int PULSE_LEN = 1,
  parameter int TIMEOUT   = 8
) (
  input  logic     clk,
  input  logic     reset,
  sr_cmd_if.slave  bus,
  input  logic     q,
  output logic     s,
  output logic     r
);

  localparam int CNT_MAX = (PULSE_LEN > TIMEOUT) ? PULSE_LEN : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_SAT      = CW'(CNT_MAX);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  sr_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic          lvl, lvl_next;
  logic          accept;

  logic done_q, skipped_q, err_q;
  logic s_d, r_d, done_d, skipped_d, err_d;

  assign bus.req_ready = (state == IDLE) && !reset;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.skipped   = skipped_q;
  assign bus.err       = err_q;

  assign accept  = bus.req_valid && bus.req_ready;
  // One counter serves both PULSE and WAIT; it holds at its ceiling.
  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

  // State register plus registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lvl       <= SR_LVL_CLR;
      s         <= 1'b0;
      r         <= 1'b0;
      done_q    <= 1'b0;
      skipped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      lvl       <= lvl_next;
      s         <= s_d;
      r         <= r_d;
      done_q    <= done_d;
      skipped_q <= skipped_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lvl_next   = lvl;
    case (state)
      IDLE: begin
        if (accept) begin
          lvl_next   = bus.req_level;
          cnt_next   = '0;
          state_next = (q == bus.req_level) ? DONE : PULSE;
        end
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      WAIT: begin
        // Match is tested first so it wins on the final timeout cycle.
        if (q == lvl) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_inc;
          if (cnt == TIMEOUT_LAST) state_next = ERR;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the flopped outputs line up
  // with the state they describe.
  always_comb begin
    s_d       = (state_next == PULSE) && (lvl_next == SR_LVL_SET);
    r_d       = (state_next == PULSE) && (lvl_next == SR_LVL_CLR);
    done_d    = (state_next == DONE);
    // DONE is only entered straight from IDLE on the skip path.
    skipped_d = (state_next == DONE) && (state == IDLE);
    err_d     = (state_next == ERR);
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Bench for sr_cmd_driver. Three instances with different timing:
//   dut 0: PULSE_LEN=1, TIMEOUT=8, SR flip-flop model attached
//   dut 1: PULSE_LEN=2, TIMEOUT=4, q driven directly by the bench
//   dut 2: PULSE_LEN=3, TIMEOUT=4, SR flip-flop model attached
// Expected outcomes are queued when a command is issued and compared when
// the DUT reports done or err.
module tb_sr_cmd_driver;
  import sr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2:0] rst    = 3'b111;
  logic [2:0] rv     = 3'b000;
  logic [2:0] rl     = 3'b000;
  logic [2:0] ovr_en = 3'b010;
  logic [2:0] ovr    = 3'b000;

  wire [2:0] q, rdy, busy, done, skipped, err, s, r;

  logic sr_both = 1'b0;

  typedef struct {
    logic done;
    logic skipped;
    logic err;
    int   lat;
    int   s_cycles;
    int   r_cycles;
  } exp_t;

  exp_t sb[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sr_cmd_if bus ();
    logic ffq = 1'b0;

    assign bus.req_valid = rv[g];
    assign bus.req_level = rl[g];
    assign rdy[g]        = bus.req_ready;
    assign busy[g]       = bus.busy;
    assign done[g]       = bus.done;
    assign skipped[g]    = bus.skipped;
    assign err[g]        = bus.err;
    assign q[g]          = ovr_en[g] ? ovr[g] : ffq;

    // Behavioural SR flip-flop; not reset by the driver's reset.
    always @(posedge clk) begin
      if (s[g])      ffq <= 1'b1;
      else if (r[g]) ffq <= 1'b0;
    end

    sr_cmd_driver #(
      .PULSE_LEN(g + 1),
      .TIMEOUT  ((g == 0) ? 8 : 4)
    ) dut (
      .clk  (clk),
      .reset(rst[g]),
      .bus  (bus),
      .q    (q[g]),
      .s    (s[g]),
      .r    (r[g])
    );
  end

  always @(negedge clk) begin
    if ((s & r) != 3'b000) sr_both <= 1'b1;
  end

  task automatic push_exp(input logic d, input logic sk, input logic er,
                          input int lat, input int sc, input int rc);
    exp_t e;
    e.done = d; e.skipped = sk; e.err = er;
    e.lat = lat; e.s_cycles = sc; e.r_cycles = rc;
    sb.push_back(e);
  endtask

  // Call at a negedge. Holds req_valid until an accepting edge; waits is
  // the number of cycles spent waiting for req_ready.
  task automatic issue(input int g, input logic lvl, output int waits);
    waits = 0;
    rv[g] = 1'b1;
    rl[g] = lvl;
    while (!rdy[g] && waits < 16) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (rdy[g] !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready dut%0d: req_ready=%b, required 1", g, rdy[g]);
    end else begin
      @(posedge clk);
    end
    #1 rv[g] = 1'b0;
  endtask

  // Counts cycles after the accept edge until done or err, then pops the
  // scoreboard and compares outcome, latency and pulse counts.
  task automatic wait_result(input int g, input string name);
    exp_t e;
    int   lat = 0;
    int   sc  = 0;
    int   rc  = 0;
    bit   got = 1'b0;
    logic d_o = 1'b0, sk_o = 1'b0, er_o = 1'b0;
    for (int k = 1; k <= 24 && !got; k++) begin
      @(negedge clk);
      if (s[g]) sc++;
      if (r[g]) rc++;
      if (done[g] || err[g]) begin
        got = 1'b1; lat = k;
        d_o = done[g]; sk_o = skipped[g]; er_o = err[g];
      end
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: queue empty, required one entry", name);
      return;
    end
    e = sb.pop_front();
    if (!got) begin
      errors++;
      $display("FAIL %s_result: no done/err within 24 cycles, required one by cycle %0d", name, e.lat);
      return;
    end
    checks++;
    if (d_o !== e.done) begin
      errors++; $display("FAIL %s_done: got %b, required %b", name, d_o, e.done);
    end
    checks++;
    if (sk_o !== e.skipped) begin
      errors++; $display("FAIL %s_skipped: got %b, required %b", name, sk_o, e.skipped);
    end
    checks++;
    if (er_o !== e.err) begin
      errors++; $display("FAIL %s_err: got %b, required %b", name, er_o, e.err);
    end
    checks++;
    if (lat != e.lat) begin
      errors++; $display("FAIL %s_latency: got N+%0d, required N+%0d", name, lat, e.lat);
    end
    checks++;
    if (sc != e.s_cycles) begin
      errors++; $display("FAIL %s_s_cycles: got %0d, required %0d", name, sc, e.s_cycles);
    end
    checks++;
    if (rc != e.r_cycles) begin
      errors++; $display("FAIL %s_r_cycles: got %0d, required %0d", name, rc, e.r_cycles);
    end
  endtask

  task automatic test_reset();
    rst = 3'b111;
    rv  = 3'b111;
    rl  = 3'b111;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({rdy, busy, done, skipped, err, s, r} !== 21'd0) begin
        errors++;
        $display("FAIL reset_outputs: rdy=%b busy=%b done=%b skipped=%b err=%b s=%b r=%b, required all 0",
                 rdy, busy, done, skipped, err, s, r);
      end
    end
    rst = 3'b000;
    rv  = 3'b000;
    #1;
    checks++;
    if (rdy !== 3'b111) begin
      errors++; $display("FAIL reset_release_ready: got %b, required 111", rdy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 3'b000) begin
      errors++; $display("FAIL reset_no_accept: busy=%b, required 000", busy);
    end
  endtask

  task automatic test_set();
    int w;
    push_exp(1'b1, 1'b0, 1'b0, 3, 1, 0);
    issue(0, SR_LVL_SET, w);
    wait_result(0, "set");
  endtask

  task automatic test_skip();
    int w;
    push_exp(1'b1, 1'b1, 1'b0, 1, 0, 0);
    issue(0, SR_LVL_SET, w);
    wait_result(0, "skip");
  endtask

  task automatic test_back_to_back();
    int w;
    push_exp(1'b1, 1'b0, 1'b0, 3, 0, 1);
    issue(0, SR_LVL_CLR, w);
    wait_result(0, "b2b_clear");
    push_exp(1'b1, 1'b1, 1'b0, 1, 0, 0);
    issue(0, SR_LVL_CLR, w);
    checks++;
    if (w != 1) begin
      errors++; $display("FAIL b2b_gap1: waited %0d cycles, required 1", w);
    end
    wait_result(0, "b2b_skip_clear");
    push_exp(1'b1, 1'b0, 1'b0, 3, 1, 0);
    issue(0, SR_LVL_SET, w);
    checks++;
    if (w != 1) begin
      errors++; $display("FAIL b2b_gap2: waited %0d cycles, required 1", w);
    end
    wait_result(0, "b2b_set");
  endtask

  task automatic test_timeout();
    int w;
    ovr[1] = 1'b0;
    push_exp(1'b0, 1'b0, 1'b1, 7, 2, 0);
    issue(1, SR_LVL_SET, w);
    wait_result(1, "timeout");
  endtask

  // rise_at: cycle after accept in which q goes high (mid-cycle).
  task automatic test_match_vs_timeout(input int rise_at, input logic expect_done, input string name);
    int w;
    ovr[1] = 1'b0;
    push_exp(expect_done, 1'b0, !expect_done, 7, 2, 0);
    issue(1, SR_LVL_SET, w);
    fork
      begin
        repeat (rise_at) @(negedge clk);
        ovr[1] = 1'b1;
      end
    join_none
    wait_result(1, name);
    @(negedge clk);
    ovr[1] = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    int w;
    issue(2, SR_LVL_SET, w);
    @(negedge clk);
    checks++;
    if (s[2] !== 1'b1) begin
      errors++; $display("FAIL mid_s_before: s=%b, required 1", s[2]);
    end
    rst[2] = 1'b1;
    @(negedge clk);
    checks++;
    if ({s[2], r[2], busy[2], done[2], err[2]} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_cleared: s=%b r=%b busy=%b done=%b err=%b, required all 0",
               s[2], r[2], busy[2], done[2], err[2]);
    end
    rst[2] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ((done[2] | err[2] | s[2]) !== 1'b0) begin
        errors++;
        $display("FAIL mid_dropped: done=%b err=%b s=%b, required 0", done[2], err[2], s[2]);
      end
    end
    push_exp(1'b1, 1'b0, 1'b0, 5, 0, 3);
    issue(2, SR_LVL_CLR, w);
    wait_result(2, "after_reset_clear");
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1);
      end
    join_none

    test_reset();
    test_set();
    test_skip();
    test_back_to_back();
    test_timeout();
    test_match_vs_timeout(6, 1'b1, "match_last");
    test_match_vs_timeout(7, 1'b0, "match_late");
    test_reset_mid_pulse();

    checks++;
    if (sr_both !== 1'b0) begin
      errors++; $display("FAIL s_and_r: observed s&&r=%b, required 0", sr_both);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
